rocev2_mem_write_engine: RTL and testbench
==========================================

Name: rocev2_mem_write_engine

Overview:
- Sits directly downstream of the RoCEv2 top on its memory-write side.
- Consumes the 96-bit write-command stream and the 512-bit write-data stream; that data stream carries no TLAST, so the block delimits beats by counting the command length.
- Produces byte-enabled 64-byte-line writes to the host-memory model, plus one status word per command.

Parameters:
- CMD_FIFO_DEPTH, 4: entries in the command buffer (power of two, >=2).
- ADDR_W, 64: address width.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- s_axis_mem_write_cmd_tdata  in  96  [63:0] byte address, [95:64] length in bytes.
- s_axis_mem_write_cmd_tvalid  in  1  command valid.
- s_axis_mem_write_cmd_tready  out  1  command FIFO not full.
- s_axis_mem_write_data_tdata  in  512  payload, byte 0 at [7:0].
- s_axis_mem_write_data_tkeep  in  64  byte valid mask.
- s_axis_mem_write_data_tvalid  in  1  data valid.
- s_axis_mem_write_data_tready  out  1  data accepted.
- mem_wr_addr  out  ADDR_W  64-byte-aligned line address.
- mem_wr_data  out  512  line data.
- mem_wr_be  out  64  byte enables.
- mem_wr_valid  out  1  write request.
- mem_wr_ready  in  1  memory accepts request.
- m_axis_wr_sts_tdata  out  33  [31:0] bytes written, [32] error.
- m_axis_wr_sts_tvalid  out  1  status valid.
- m_axis_wr_sts_tready  in  1  status accepted.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; FIFO empty; counters 0. Reset mid-command abandons the command with no status. Remaining beats of that command are not flushed; upstream is reset together with this block.
- Commands enter the FIFO on tvalid&&tready. tready = !full. Push and pop may occur in the same cycle when full.
- IDLE: if FIFO non-empty, pop the head into cur_addr, cur_len, remaining = len. Next state:
  - len==0 -> STS, error=0.
  - addr[5:0]!=0 -> DROP, error=1.
  - otherwise -> WRITE.
  - 1 cycle per decision.
- WRITE: data tready = !mem_wr_valid || mem_wr_ready (registered output stage, no bubble at full throughput).
- On each accepted beat:
  - Register mem_wr_addr = cur_addr, mem_wr_data = tdata.
  - mem_wr_be = tkeep & lenmask. lenmask = all ones if remaining>=64, else low `remaining` bits set.
  - mem_wr_valid = 1.
  - cur_addr += 64; remaining -= min(remaining, 64).
  - If remaining<=64 before the beat, go to STS.
- Latency: beat accepted at cycle N -> mem_wr_valid at N+1. mem_wr_valid holds, with stable payload, until mem_wr_ready.
- DROP: data tready = 1. Beats are counted as in WRITE but never written. Leave for STS when remaining<=64.
- STS:
  - Entry waits until mem_wr_valid is 0, so the last write has been accepted first.
  - Then drive m_axis_wr_sts_tvalid with {error, len}. When error=1, the reported length is the original len.
  - Hold until tready, then go to IDLE.
  - Data tready = 0 in IDLE and STS.
- Arithmetic: remaining and len are 32-bit unsigned. A partial final beat is masked by lenmask regardless of tkeep. Address add wraps modulo 2^ADDR_W.
- Data beats arriving before their command are held off (tready=0). No ordering relation is assumed between the two input streams beyond per-command byte count.

Decomposition:
- Shared package rocev2_mem_pkg:
  - Command field offsets (ADDR_LSB=0, LEN_LSB=64).
  - LINE_BYTES=64.
  - Status layout constants.
  - FSM state typedef {IDLE, WRITE, DROP, STS}.
- Sub-module: rocev2_cmd_fifo. Synchronous FIFO, parameterised width/depth, with full/empty outputs.

Test Plan:
- Cmd addr=0x1000, len=128; two beats, tkeep all ones, mem_wr_ready=1 -> writes at 0x1000 and 0x1040 with be all ones on back-to-back cycles; then status {0,128}.
- Cmd addr=0x2000, len=100; two beats -> second write at 0x2040 with be=0x0000000F_FFFFFFFF (36 bytes); status {0,100}.
- Cmd addr=0x3004, len=70; two beats -> no mem writes; both beats accepted; status {1,70}.
- Cmd len=0 followed by cmd addr=0x0, len=64 -> status {0,0} first, then one write at 0x0 and status {0,64}.
- Push 5 cmds with data stalled -> cmd tready drops after 4. mem_wr_ready toggling 0/1 -> each write held stable until accepted, no beat lost, addresses strictly increasing.
- Assert rst mid-WRITE after 1 of 3 beats -> next cycle all outputs 0 and FIFO empty; a new cmd addr=0x40, len=64 completes normally with status {0,64}.

Source files
------------

// File: rtl/rocev2_mem_pkg.sv
`default_nettype none
//==============================================================================
// Module      : rocev2_mem_pkg
// Description : Shared constants, state type and helpers for the RoCEv2
//               memory-write engine.
// Revision    : 1.0 - initial release
//==============================================================================
package rocev2_mem_pkg;

    localparam int ADDR_LSB    = 0;
    localparam int LEN_LSB     = 64;
    localparam int LEN_W       = 32;
    localparam int CMD_W       = 96;
    localparam int LINE_BYTES  = 64;
    localparam int LINE_OFS_W  = 6;
    localparam int DATA_W      = 512;
    localparam int STS_LEN_LSB = 0;
    localparam int STS_ERR_BIT = 32;
    localparam int STS_W       = 33;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2,
        STS   = 2'd3
    } wr_state_e;

    // Byte mask covering the bytes still owed by the current command on this beat.
    function automatic logic [LINE_BYTES-1:0] line_len_mask(input logic [LEN_W-1:0] remaining);
        logic [LINE_BYTES-1:0] one;
        one = {{(LINE_BYTES-1){1'b0}}, 1'b1};
        if (remaining >= LEN_W'(LINE_BYTES)) begin
            return '1;
        end
        return (one << remaining[LINE_OFS_W-1:0]) - one;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rocev2_cmd_fifo.sv
`default_nettype none
//==============================================================================
// Module      : rocev2_cmd_fifo
// Description : Synchronous FIFO with full/empty flags; push is accepted when
//               full if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
//==============================================================================
module rocev2_cmd_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full     = (r_count == c_depth);
    assign o_empty    = (r_count == '0);
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + c_cnt_w'(1);
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rocev2_mem_write_engine.sv
`default_nettype none
//==============================================================================
// Module      : rocev2_mem_write_engine
// Description : Turns write commands plus an untagged 512-bit data stream into
//               byte-enabled 64-byte line writes and one status per command.
// Revision    : 1.0 - initial release
//==============================================================================
module rocev2_mem_write_engine
    import rocev2_mem_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [95:0]       s_axis_mem_write_cmd_tdata,
    input  logic              s_axis_mem_write_cmd_tvalid,
    output logic              s_axis_mem_write_cmd_tready,
    input  logic [511:0]      s_axis_mem_write_data_tdata,
    input  logic [63:0]       s_axis_mem_write_data_tkeep,
    input  logic              s_axis_mem_write_data_tvalid,
    output logic              s_axis_mem_write_data_tready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [511:0]      mem_wr_data,
    output logic [63:0]       mem_wr_be,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [32:0]       m_axis_wr_sts_tdata,
    output logic              m_axis_wr_sts_tvalid,
    input  logic              m_axis_wr_sts_tready
);

    wr_state_e          r_state;
    wr_state_e          w_state_next;

    logic [CMD_W-1:0]   w_fifo_dout;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_cmd_push;
    logic               w_cmd_pop;
    logic [ADDR_W-1:0]  w_pop_addr;
    logic [LEN_W-1:0]   w_pop_len;
    logic               w_pop_misaligned;

    logic [ADDR_W-1:0]  r_cur_addr;
    logic [LEN_W-1:0]   r_cur_len;
    logic [LEN_W-1:0]   r_remaining;
    logic               r_error;

    logic [ADDR_W-1:0]  r_mem_wr_addr;
    logic [DATA_W-1:0]  r_mem_wr_data;
    logic [LINE_BYTES-1:0] r_mem_wr_be;
    logic               r_mem_wr_valid;

    logic               w_data_ready;
    logic               w_beat;
    logic               w_last_beat;
    logic [LEN_W-1:0]   w_step;
    logic               w_sts_valid;

    assign w_cmd_push = s_axis_mem_write_cmd_tvalid && !w_fifo_full;

    rocev2_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_cmd_push),
        .i_push_data (s_axis_mem_write_cmd_tdata),
        .i_pop       (w_cmd_pop),
        .o_pop_data  (w_fifo_dout),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    assign w_pop_addr       = w_fifo_dout[ADDR_LSB +: ADDR_W];
    assign w_pop_len        = w_fifo_dout[LEN_LSB +: LEN_W];
    assign w_pop_misaligned = (w_pop_addr[LINE_OFS_W-1:0] != '0);

    // The output register drains while a new beat is loaded, so no bubble at full rate.
    assign w_data_ready = (r_state == DROP) ||
                          ((r_state == WRITE) && (!r_mem_wr_valid || mem_wr_ready));
    assign w_beat       = s_axis_mem_write_data_tvalid && w_data_ready;
    assign w_last_beat  = (r_remaining <= LEN_W'(LINE_BYTES));
    assign w_step       = w_last_beat ? r_remaining : LEN_W'(LINE_BYTES);
    assign w_sts_valid  = (r_state == STS) && !r_mem_wr_valid;

    always_comb begin
        w_state_next = r_state;
        w_cmd_pop    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_fifo_empty) begin
                    w_cmd_pop = 1'b1;
                    if (w_pop_len == '0) begin
                        w_state_next = STS;
                    end else if (w_pop_misaligned) begin
                        w_state_next = DROP;
                    end else begin
                        w_state_next = WRITE;
                    end
                end
            end
            WRITE, DROP: begin
                if (w_beat && w_last_beat) begin
                    w_state_next = STS;
                end
            end
            STS: begin
                if (w_sts_valid && m_axis_wr_sts_tready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_addr     <= '0;
            r_cur_len      <= '0;
            r_remaining    <= '0;
            r_error        <= 1'b0;
            r_mem_wr_addr  <= '0;
            r_mem_wr_data  <= '0;
            r_mem_wr_be    <= '0;
            r_mem_wr_valid <= 1'b0;
        end else begin
            if (w_cmd_pop) begin
                r_cur_addr  <= w_pop_addr;
                r_cur_len   <= w_pop_len;
                r_remaining <= w_pop_len;
                r_error     <= (w_pop_len != '0) && w_pop_misaligned;
            end else if (w_beat) begin
                r_cur_addr  <= r_cur_addr + ADDR_W'(LINE_BYTES);
                r_remaining <= r_remaining - w_step;
            end

            if (w_beat && (r_state == WRITE)) begin
                r_mem_wr_addr  <= r_cur_addr;
                r_mem_wr_data  <= s_axis_mem_write_data_tdata;
                r_mem_wr_be    <= s_axis_mem_write_data_tkeep & line_len_mask(r_remaining);
                r_mem_wr_valid <= 1'b1;
            end else if (mem_wr_ready) begin
                r_mem_wr_valid <= 1'b0;
            end
        end
    end

    assign s_axis_mem_write_cmd_tready  = !w_fifo_full;
    assign s_axis_mem_write_data_tready = w_data_ready;
    assign mem_wr_addr                  = r_mem_wr_addr;
    assign mem_wr_data                  = r_mem_wr_data;
    assign mem_wr_be                    = r_mem_wr_be;
    assign mem_wr_valid                 = r_mem_wr_valid;
    assign m_axis_wr_sts_tvalid         = w_sts_valid;
    assign m_axis_wr_sts_tdata          = {r_error, r_cur_len};

endmodule
`default_nettype wire

// File: tb/tb_rocev2_mem_write_engine.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_rocev2_mem_write_engine
// Description : Self-checking bench for the memory-write engine with a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_rocev2_mem_write_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [95:0]  cmd_tdata;
    logic         cmd_tvalid;
    logic         cmd_tready;
    logic [511:0] data_tdata;
    logic [63:0]  data_tkeep;
    logic         data_tvalid;
    logic         data_tready;
    logic [63:0]  mem_wr_addr;
    logic [511:0] mem_wr_data;
    logic [63:0]  mem_wr_be;
    logic         mem_wr_valid;
    logic         mem_wr_ready;
    logic [32:0]  sts_tdata;
    logic         sts_tvalid;
    logic         sts_tready;

    always #5 clk = ~clk;

    rocev2_mem_write_engine #(
        .CMD_FIFO_DEPTH (4),
        .ADDR_W         (64)
    ) dut (
        .clk                          (clk),
        .rst                          (rst),
        .s_axis_mem_write_cmd_tdata   (cmd_tdata),
        .s_axis_mem_write_cmd_tvalid  (cmd_tvalid),
        .s_axis_mem_write_cmd_tready  (cmd_tready),
        .s_axis_mem_write_data_tdata  (data_tdata),
        .s_axis_mem_write_data_tkeep  (data_tkeep),
        .s_axis_mem_write_data_tvalid (data_tvalid),
        .s_axis_mem_write_data_tready (data_tready),
        .mem_wr_addr                  (mem_wr_addr),
        .mem_wr_data                  (mem_wr_data),
        .mem_wr_be                    (mem_wr_be),
        .mem_wr_valid                 (mem_wr_valid),
        .mem_wr_ready                 (mem_wr_ready),
        .m_axis_wr_sts_tdata          (sts_tdata),
        .m_axis_wr_sts_tvalid         (sts_tvalid),
        .m_axis_wr_sts_tready         (sts_tready)
    );

    typedef struct { logic [511:0] d; logic [63:0] k; } beat_t;
    typedef struct { logic [63:0] a; logic [511:0] d; logic [63:0] be; } wr_t;
    typedef struct { logic [32:0] s; int nwr; } sts_t;

    logic [95:0] cmd_q[$];
    beat_t       data_q[$];
    wr_t         exp_wr_q[$];
    sts_t        exp_sts_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_done = 0;
    int exp_wr_total = 0;
    int cmds_accepted = 0;
    int last_wr_cyc = -10;
    int wr_gap = 0;
    logic [63:0] last_be = '0;
    int cmd_gap = 0;
    int data_gap = 0;
    int rdy_pct = 100;
    int sts_pct = 100;
    bit data_en = 1'b1;

    task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total = total + 1;
        if (obs !== exp) begin
            bad = bad + 1;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: a command becomes ceil(len/64) beats; aligned commands
    // write each beat to addr+64*i with the keep clipped to the bytes still owed.
    task automatic add_cmd(input logic [63:0] addr, input logic [31:0] len, input bit full_keep);
        int    nb;
        int    left;
        beat_t b;
        wr_t   w;
        sts_t  s;
        logic [63:0] mask;
        nb = (int'(len) + 63) / 64;
        cmd_q.push_back({len, addr});
        for (int i = 0; i < nb; i++) begin
            b.d = rand512();
            b.k = full_keep ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            data_q.push_back(b);
            if (addr[5:0] == 6'd0) begin
                left = int'(len) - 64 * i;
                mask = (left >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << left) - 64'd1);
                w.a  = addr + 64'(64 * i);
                w.d  = b.d;
                w.be = b.k & mask;
                exp_wr_q.push_back(w);
                exp_wr_total++;
            end
        end
        s.s   = {(len != 0) && (addr[5:0] != 6'd0), len};
        s.nwr = exp_wr_total;
        exp_sts_q.push_back(s);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_wr_q.size() + exp_sts_q.size() + data_q.size() + cmd_q.size()) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", exp_wr_q.size() + exp_sts_q.size() + data_q.size() + cmd_q.size(), 0);
        @(posedge clk);
        #2;
    endtask

    // Driver and monitor: handshakes are sampled on the falling edge, inputs change 1ns after the rising edge.
    initial begin
        bit c_fire;
        bit d_fire;
        bit pend;
        logic [63:0]  pa;
        logic [511:0] pd;
        logic [63:0]  pb;
        wr_t  w;
        sts_t s;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            c_fire = cmd_tvalid && cmd_tready && !rst;
            d_fire = data_tvalid && data_tready && !rst;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    check_eq("wr_hold_valid", mem_wr_valid, 1);
                    check_eq("wr_hold_addr", mem_wr_addr, pa);
                    check_eq("wr_hold_data", mem_wr_data, pd);
                    check_eq("wr_hold_be", mem_wr_be, pb);
                end
                pend = mem_wr_valid && !mem_wr_ready;
                pa = mem_wr_addr;
                pd = mem_wr_data;
                pb = mem_wr_be;
                if (mem_wr_valid && mem_wr_ready) begin
                    if (exp_wr_q.size() == 0) begin
                        check_eq("wr_unexpected", mem_wr_valid, 0);
                    end else begin
                        w = exp_wr_q.pop_front();
                        check_eq("wr_addr", mem_wr_addr, w.a);
                        check_eq("wr_data", mem_wr_data, w.d);
                        check_eq("wr_be", mem_wr_be, w.be);
                    end
                    wr_done++;
                    wr_gap = cyc - last_wr_cyc;
                    last_wr_cyc = cyc;
                    last_be = mem_wr_be;
                end
                if (sts_tvalid && sts_tready) begin
                    if (exp_sts_q.size() == 0) begin
                        check_eq("sts_unexpected", sts_tvalid, 0);
                    end else begin
                        s = exp_sts_q.pop_front();
                        check_eq("sts_data", sts_tdata, s.s);
                        check_eq("sts_after_writes", wr_done, s.nwr);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (c_fire) begin
                void'(cmd_q.pop_front());
                cmds_accepted++;
            end
            if (d_fire) void'(data_q.pop_front());
            if (!(cmd_tvalid && !c_fire)) begin
                if (cmd_q.size() > 0 && $urandom_range(99) >= cmd_gap) begin
                    cmd_tvalid = 1'b1;
                    cmd_tdata  = cmd_q[0];
                end else begin
                    cmd_tvalid = 1'b0;
                end
            end
            if (!(data_tvalid && !d_fire)) begin
                if (data_en && data_q.size() > 0 && $urandom_range(99) >= data_gap) begin
                    data_tvalid = 1'b1;
                    data_tdata  = data_q[0].d;
                    data_tkeep  = data_q[0].k;
                end else begin
                    data_tvalid = 1'b0;
                end
            end
            mem_wr_ready = ($urandom_range(99) < rdy_pct);
            sts_tready   = ($urandom_range(99) < sts_pct);
        end
    end

    initial begin
        int    base;
        beat_t b;
        wr_t   w;
        logic [63:0] addr;
        logic [31:0] len;
        rst          = 1'b1;
        cmd_tdata    = '0;
        cmd_tvalid   = 1'b0;
        data_tdata   = '0;
        data_tkeep   = '0;
        data_tvalid  = 1'b0;
        mem_wr_ready = 1'b1;
        sts_tready   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_wr_valid", mem_wr_valid, 0);
        check_eq("rst_wr_addr", mem_wr_addr, 0);
        check_eq("rst_wr_be", mem_wr_be, 0);
        check_eq("rst_sts_valid", sts_tvalid, 0);
        check_eq("rst_sts_data", sts_tdata, 0);
        check_eq("rst_data_ready", data_tready, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Two full aligned beats, back to back.
        add_cmd(64'h1000, 32'd128, 1'b1);
        drain(200);
        check_eq("t1_wr_gap", wr_gap, 1);

        // Partial final beat is clipped to 36 bytes.
        add_cmd(64'h2000, 32'd100, 1'b1);
        drain(200);
        check_eq("t2_last_be", last_be, 64'h0000_000F_FFFF_FFFF);

        // Misaligned: beats swallowed, error status.
        base = wr_done;
        add_cmd(64'h3004, 32'd70, 1'b1);
        drain(200);
        check_eq("t3_no_writes", wr_done, base);

        // Zero length then a single line.
        add_cmd(64'h0, 32'd0, 1'b1);
        add_cmd(64'h0, 32'd64, 1'b1);
        drain(200);

        // Command backpressure with data stalled, then ready toggling.
        data_en = 1'b0;
        base = cmds_accepted;
        for (int i = 0; i < 6; i++) add_cmd(64'h10000 + 64'(i * 256), 32'd128, 1'b0);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_eq("t5_cmds_accepted", cmds_accepted - base, 5);
        check_eq("t5_cmd_tready", cmd_tready, 0);
        @(posedge clk);
        #2;
        rdy_pct = 50;
        data_en = 1'b1;
        drain(2000);

        // Reset in the middle of a three-beat command.
        rdy_pct = 100;
        base = wr_done;
        cmd_q.push_back({32'd192, 64'h80});
        b.d = rand512();
        b.k = 64'hFFFF_FFFF_FFFF_FFFF;
        data_q.push_back(b);
        w.a = 64'h80;
        w.d = b.d;
        w.be = b.k;
        exp_wr_q.push_back(w);
        exp_wr_total++;
        for (int n = 0; n < 50 && wr_done == base; n++) @(posedge clk);
        check_eq("t6_first_wr", wr_done, base + 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_wr_q.delete();
        exp_sts_q.delete();
        data_q.delete();
        cmd_q.delete();
        cmd_tvalid  = 1'b0;
        data_tvalid = 1'b0;
        exp_wr_total = wr_done;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_rst_wr_valid", mem_wr_valid, 0);
        check_eq("t6_rst_wr_addr", mem_wr_addr, 0);
        check_eq("t6_rst_wr_data", mem_wr_data, 0);
        check_eq("t6_rst_sts_valid", sts_tvalid, 0);
        check_eq("t6_rst_data_ready", data_tready, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("t6_idle_data_ready", data_tready, 0);
        check_eq("t6_cmd_tready", cmd_tready, 1);
        @(posedge clk);
        #2;
        add_cmd(64'h40, 32'd64, 1'b1);
        drain(200);

        // Randomized traffic with gaps and backpressure on every interface.
        cmd_gap  = 30;
        data_gap = 30;
        rdy_pct  = 70;
        sts_pct  = 70;
        for (int i = 0; i < 40; i++) begin
            addr = {$urandom, $urandom} & ~64'h3F;
            if ($urandom_range(5) == 0) addr[5:0] = 6'($urandom_range(63, 1));
            case ($urandom_range(3))
                0: len = 32'($urandom_range(64, 1));
                1: len = 32'($urandom_range(320, 65));
                2: len = 32'(64 * $urandom_range(4, 1));
                default: len = ($urandom_range(2) == 0) ? 32'd0 : 32'($urandom_range(200, 1));
            endcase
            add_cmd(addr, len, 1'($urandom_range(1)));
        end
        add_cmd(64'hFFFF_FFFF_FFFF_FFC0, 32'd128, 1'b0);
        drain(20000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
